item_memory_fetch_ctrl: RTL



---
 rtl/item_memory_fetch_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/item_memory_fetch_ctrl.sv
// Strided dual-channel source fetch sequencer feeding item memory ports A/B.
// Optional stall counter output enabled by defining ITEM_FETCH_PERF_CNT_EN.
module item_memory_fetch_ctrl #(
    parameter int ImAddrWidth  = 10,
    parameter int SrcAddrWidth = 16,
    parameter int CountWidth   = 16,
    parameter int BufDepth     = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    clr_i,
    input  logic [CountWidth-1:0]   num_items_i,
    input  logic                    a_en_i,
    input  logic                    b_en_i,
    input  logic [SrcAddrWidth-1:0] a_base_i,
    input  logic [SrcAddrWidth-1:0] b_base_i,
    input  logic [SrcAddrWidth-1:0] a_stride_i,
    input  logic [SrcAddrWidth-1:0] b_stride_i,
    output logic                    mem_req_o,
    output logic [SrcAddrWidth-1:0] mem_addr_o,
    input  logic [ImAddrWidth-1:0]  mem_rdata_i,
    output logic [ImAddrWidth-1:0]  lowdim_a_o,
    output logic [ImAddrWidth-1:0]  lowdim_b_o,
    output logic                    a_valid_o,
    output logic                    b_valid_o,
    input  logic                    a_ready_i,
    input  logic                    b_ready_i,
    output logic                    busy_o,
    output logic                    done_o
`ifdef ITEM_FETCH_PERF_CNT_EN
    ,
    output logic [CountWidth-1:0]   stall_cnt_o
`endif
);

    localparam int PW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam int OW = $clog2(BufDepth + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state_q;
    logic [CountWidth-1:0]   num_q;
    logic [1:0]              en_q;
    logic [SrcAddrWidth-1:0] addr_q   [2];
    logic [SrcAddrWidth-1:0] stride_q [2];
    logic [CountWidth-1:0]   iss_q    [2];
    logic                    rr_q;
    logic                    infl_q;
    logic                    tag_q;

    logic [ImAddrWidth-1:0]  fifo_q   [2][BufDepth];
    logic [PW-1:0]           rd_ptr_q [2];
    logic [PW-1:0]           wr_ptr_q [2];
    logic [OW-1:0]           cnt_q    [2];

    logic [1:0]              rdy;
    logic [1:0]              valid;
    logic [1:0]              pop;
    logic [1:0]              wr_en;
    logic [1:0]              ch_done;
    logic [1:0]              elig;
    logic [ImAddrWidth-1:0]  head [2];
    logic [OW:0]             occ  [2];
    logic                    req;
    logic                    gnt;
    logic                    all_issued;
    logic                    bufs_empty;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(BufDepth - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Buffer status, credit-based eligibility and round-robin grant.
    always_comb begin
        rdy     = {b_ready_i, a_ready_i};
        valid   = '0;
        pop     = '0;
        wr_en   = '0;
        ch_done = '0;
        elig    = '0;
        for (int c = 0; c < 2; c++) begin
            valid[c]   = cnt_q[c] != '0;
            head[c]    = valid[c] ? fifo_q[c][rd_ptr_q[c]] : '0;
            pop[c]     = valid[c] && rdy[c];
            wr_en[c]   = infl_q && (tag_q == 1'(c));
            occ[c]     = {1'b0, cnt_q[c]} + (OW+1)'(wr_en[c])
                         - (OW+1)'(pop[c]);
            ch_done[c] = !en_q[c] || (iss_q[c] == num_q);
            elig[c]    = (state_q == RUN) && !ch_done[c]
                         && (occ[c] < (OW+1)'(BufDepth));
        end
        req        = elig[0] || elig[1];
        gnt        = (elig[0] && elig[1]) ? rr_q : elig[1];
        all_issued = ch_done[0] && ch_done[1];
        bufs_empty = (cnt_q[0] == '0) && (cnt_q[1] == '0);
    end

    assign mem_req_o  = req;
    assign mem_addr_o = req ? addr_q[gnt] : '0;
    assign a_valid_o  = valid[0];
    assign b_valid_o  = valid[1];
    assign lowdim_a_o = head[0];
    assign lowdim_b_o = head[1];
    assign busy_o     = state_q != IDLE;
    assign done_o     = state_q == DONE;

    // Job FSM, config latch, address walkers and in-flight tag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            num_q    <= '0;
            en_q     <= '0;
            rr_q     <= 1'b0;
            infl_q   <= 1'b0;
            tag_q    <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                addr_q[c]   <= '0;
                stride_q[c] <= '0;
                iss_q[c]    <= '0;
            end
        end else if (clr_i) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            infl_q  <= 1'b0;
            tag_q   <= 1'b0;
        end else begin
            infl_q <= req;
            if (req) begin
                tag_q       <= gnt;
                rr_q        <= ~gnt;
                addr_q[gnt] <= addr_q[gnt] + stride_q[gnt];
                iss_q[gnt]  <= iss_q[gnt] + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        num_q       <= num_items_i;
                        en_q        <= {b_en_i, a_en_i};
                        addr_q[0]   <= a_base_i;
                        addr_q[1]   <= b_base_i;
                        stride_q[0] <= a_stride_i;
                        stride_q[1] <= b_stride_i;
                        iss_q[0]    <= '0;
                        iss_q[1]    <= '0;
                        rr_q        <= 1'b0;
                        if (num_items_i == '0 || !(a_en_i || b_en_i))
                            state_q <= DONE;
                        else
                            state_q <= RUN;
                    end
                end
                RUN: begin
                    if (all_issued) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!infl_q && bufs_empty) state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Per-channel output FIFOs: capture returned data, pop on handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            for (int c = 0; c < 2; c++) begin
                rd_ptr_q[c] <= '0;
                wr_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (wr_en[c]) begin
                    fifo_q[c][wr_ptr_q[c]] <= mem_rdata_i;
                    wr_ptr_q[c] <= ptr_inc(wr_ptr_q[c]);
                end
                if (pop[c]) rd_ptr_q[c] <= ptr_inc(rd_ptr_q[c]);
                cnt_q[c] <= cnt_q[c] + OW'(wr_en[c]) - OW'(pop[c]);
            end
        end
    end

`ifdef ITEM_FETCH_PERF_CNT_EN
    logic stall;
    assign stall = (valid[0] && !rdy[0]) || (valid[1] && !rdy[1]);

    // Saturating count of active cycles with a symbol held back.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            stall_cnt_o <= '0;
        end else if (state_q == IDLE && start_i) begin
            stall_cnt_o <= '0;
        end else if ((state_q == RUN || state_q == DRAIN) && stall
                     && stall_cnt_o != '1) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
`endif

endmodule
